// File: rtl/pio_bank_gen.sv
// Avalon-MM parallel I/O bank: synchronised and debounced inputs with edge
// capture and a maskable level interrupt, plus an output register with atomic set/clear.
module pio_bank_gen #(
    parameter int unsigned          IN_WIDTH        = 8,
    parameter int unsigned          OUT_WIDTH       = 8,
    parameter int unsigned          DEBOUNCE_CYCLES = 16,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  in_export,
    output logic [OUT_WIDTH-1:0] out_export,
    output logic                 irq
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_OUT      = 3'd1,
        ADDR_OUTSET   = 3'd2,
        ADDR_OUTCLR   = 3'd3,
        ADDR_IRQMASK  = 3'd4,
        ADDR_EDGECAP  = 3'd5,
        ADDR_EDGEMODE = 3'd6,
        ADDR_RSVD     = 3'd7
    } addr_e;

    typedef enum logic [1:0] {
        MODE_RISE = 2'd0,
        MODE_FALL = 2'd1,
        MODE_BOTH = 2'd2,
        MODE_OFF  = 2'd3
    } mode_e;

    logic [IN_WIDTH-1:0]  r_sync1, r_sync2, w_deb, r_deb_d1;
    logic [IN_WIDTH-1:0]  r_edgecap, r_irqmask, w_edge, w_cap_clr;
    logic [OUT_WIDTH-1:0] r_out;
    logic [31:0]          r_rdata, w_rdata;
    mode_e                r_mode;
    logic                 r_irq;
    addr_e                w_addr;
    logic                 w_unused;

    assign w_addr   = addr_e'(avs_address);
    assign w_unused = ^avs_writedata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_export;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign w_deb = r_sync2;
        end else begin : g_deb
            localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [IN_WIDTH-1:0] r_deb;
            logic [CW-1:0]       r_cnt [IN_WIDTH];

            // A mismatch must persist DEBOUNCE_CYCLES cycles; any agreement restarts the count.
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    r_deb <= '0;
                    for (int unsigned i = 0; i < IN_WIDTH; i++) r_cnt[i] <= '0;
                end else begin
                    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
                        if (r_sync2[i] == r_deb[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_deb[i] <= r_sync2[i];
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CW'(1);
                        end
                    end
                end
            end
            assign w_deb = r_deb;
        end
    endgenerate

    always_comb begin
        w_edge = '0;
        case (r_mode)
            MODE_RISE: w_edge = w_deb & ~r_deb_d1;
            MODE_FALL: w_edge = ~w_deb & r_deb_d1;
            MODE_BOTH: w_edge = w_deb ^ r_deb_d1;
            default:   w_edge = '0;
        endcase
    end

    assign w_cap_clr = (avs_write && w_addr == ADDR_EDGECAP) ? avs_writedata[IN_WIDTH-1:0] : '0;

    // New edges are OR-ed in after the clear so a coincident edge keeps its bit set.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_deb_d1  <= '0;
            r_edgecap <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_deb_d1  <= w_deb;
            r_edgecap <= (r_edgecap & ~w_cap_clr) | w_edge;
            r_irq     <= |(r_edgecap & r_irqmask);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_out     <= OUT_RESET;
            r_irqmask <= '0;
            r_mode    <= MODE_RISE;
        end else if (avs_write) begin
            case (w_addr)
                ADDR_OUT:      r_out     <= avs_writedata[OUT_WIDTH-1:0];
                ADDR_OUTSET:   r_out     <= r_out | avs_writedata[OUT_WIDTH-1:0];
                ADDR_OUTCLR:   r_out     <= r_out & ~avs_writedata[OUT_WIDTH-1:0];
                ADDR_IRQMASK:  r_irqmask <= avs_writedata[IN_WIDTH-1:0];
                ADDR_EDGEMODE: r_mode    <= mode_e'(avs_writedata[1:0]);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_DATA:     w_rdata[IN_WIDTH-1:0]  = w_deb;
            ADDR_OUT:      w_rdata[OUT_WIDTH-1:0] = r_out;
            ADDR_IRQMASK:  w_rdata[IN_WIDTH-1:0]  = r_irqmask;
            ADDR_EDGECAP:  w_rdata[IN_WIDTH-1:0]  = r_edgecap;
            ADDR_EDGEMODE: w_rdata[1:0]           = r_mode;
            default:       w_rdata                = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rdata <= '0;
        end else if (avs_read) begin
            r_rdata <= w_rdata;
        end
    end

    assign avs_readdata = r_rdata;
    assign out_export   = r_out;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pio_bank_gen.sv
// Bench for pio_bank_gen: register-access vector table plus timed sequences
// for debounce, edge capture, interrupt and mid-operation reset.
module tb_pio_bank_gen;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [7:0]  in_export;
    logic [7:0]  out_export;
    logic        irq;

    always #5 clk_clk = ~clk_clk;

    pio_bank_gen #(
        .IN_WIDTH(8),
        .OUT_WIDTH(8),
        .DEBOUNCE_CYCLES(16),
        .OUT_RESET(8'hA5)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .in_export(in_export),
        .out_export(out_export),
        .irq(irq)
    );

    typedef struct {
        logic [2:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        rd_d;
    vec_t        vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Scoreboard: read data is compared on the falling edge after the sampling edge.
    always @(posedge clk_clk) rd_d <= avs_read;
    always @(negedge clk_clk) begin
        if (rd_d === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got read data %h with no expected entry", avs_readdata);
            end else begin
                chk("readdata", avs_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic bus(input logic [2:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [31:0] expr);
        avs_address   = a;
        avs_read      = rd;
        avs_write     = wr;
        avs_writedata = wd;
        if (rd) exp_q.push_back(expr);
        cyc();
        idle();
    endtask

    function automatic vec_t mk(input logic [2:0] a, input logic rd, input logic wr,
                                input logic [31:0] wd, input logic [31:0] er, input logic [7:0] eo);
        vec_t v;
        v.addr = a; v.rd = rd; v.wr = wr; v.wd = wd; v.exp_rd = er; v.exp_out = eo;
        return v;
    endfunction

    initial begin
        reset_reset_n = 1'b0;
        in_export     = '0;
        avs_address   = '0;
        avs_writedata = '0;
        idle();

        vt.push_back(mk(3'd0, 1, 0, 32'h0,        32'h0,  8'hA5));
        vt.push_back(mk(3'd4, 1, 0, 32'h0,        32'h0,  8'hA5));
        vt.push_back(mk(3'd5, 1, 0, 32'h0,        32'h0,  8'hA5));
        vt.push_back(mk(3'd6, 1, 0, 32'h0,        32'h0,  8'hA5));
        vt.push_back(mk(3'd7, 1, 0, 32'h0,        32'h0,  8'hA5));
        vt.push_back(mk(3'd1, 1, 0, 32'h0,        32'hA5, 8'hA5));
        vt.push_back(mk(3'd1, 0, 1, 32'h0F,       32'h0,  8'h0F));
        vt.push_back(mk(3'd2, 0, 1, 32'h30,       32'h0,  8'h3F));
        vt.push_back(mk(3'd3, 0, 1, 32'h03,       32'h0,  8'h3C));
        vt.push_back(mk(3'd1, 1, 0, 32'h0,        32'h3C, 8'h3C));
        vt.push_back(mk(3'd2, 1, 0, 32'h0,        32'h0,  8'h3C));
        vt.push_back(mk(3'd3, 1, 0, 32'h0,        32'h0,  8'h3C));
        vt.push_back(mk(3'd2, 0, 1, 32'hFFFFFF00, 32'h0,  8'h3C));
        vt.push_back(mk(3'd3, 0, 1, 32'hFFFFFF00, 32'h0,  8'h3C));
        vt.push_back(mk(3'd1, 1, 1, 32'h55,       32'h3C, 8'h55));
        vt.push_back(mk(3'd1, 1, 0, 32'h0,        32'h55, 8'h55));
        vt.push_back(mk(3'd1, 0, 1, 32'h3C,       32'h0,  8'h3C));
        vt.push_back(mk(3'd0, 0, 1, 32'hFF,       32'h0,  8'h3C));
        vt.push_back(mk(3'd0, 1, 0, 32'h0,        32'h0,  8'h3C));
        vt.push_back(mk(3'd7, 0, 1, 32'hFFFFFFFF, 32'h0,  8'h3C));
        vt.push_back(mk(3'd7, 1, 0, 32'h0,        32'h0,  8'h3C));
        vt.push_back(mk(3'd4, 0, 1, 32'h1FF,      32'h0,  8'h3C));
        vt.push_back(mk(3'd4, 1, 0, 32'h0,        32'hFF, 8'h3C));
        vt.push_back(mk(3'd6, 0, 1, 32'hFFFFFFFE, 32'h0,  8'h3C));
        vt.push_back(mk(3'd6, 1, 0, 32'h0,        32'h2,  8'h3C));
        vt.push_back(mk(3'd6, 0, 1, 32'h0,        32'h0,  8'h3C));
        vt.push_back(mk(3'd6, 1, 0, 32'h0,        32'h0,  8'h3C));
        vt.push_back(mk(3'd4, 0, 1, 32'h1,        32'h0,  8'h3C));
        vt.push_back(mk(3'd4, 1, 0, 32'h0,        32'h1,  8'h3C));

        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_out", {24'h0, out_export}, 32'hA5);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cyc();

        foreach (vt[i]) begin
            bus(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].wd, vt[i].exp_rd);
            chk($sformatf("vec%0d_out", i), {24'h0, out_export}, {24'h0, vt[i].exp_out});
        end

        // 10-cycle glitch on bit 0 must not reach DATA
        in_export[0] = 1'b1;
        repeat (10) cyc();
        in_export[0] = 1'b0;
        repeat (25) cyc();
        bus(3'd0, 1, 0, 0, 32'h0);
        bus(3'd5, 1, 0, 0, 32'h0);
        chk("glitch_irq", {31'h0, irq}, 32'h0);

        // Held high: deb set 18 edges after the pin change, capture one later, irq one after that
        in_export[0] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            avs_read    = 1'b1;
            avs_address = (k <= 19) ? 3'd0 : 3'd5;
            exp_q.push_back((k <= 18) ? 32'h0 : 32'h1);
            cyc();
            chk($sformatf("rise_irq_k%0d", k), {31'h0, irq}, (k >= 20) ? 32'h1 : 32'h0);
        end
        idle();

        bus(3'd5, 0, 1, 32'h1, 32'h0);
        chk("w1c_irq_hold", {31'h0, irq}, 32'h1);
        cyc();
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);
        bus(3'd5, 1, 0, 0, 32'h0);

        in_export[0] = 1'b0;
        repeat (25) cyc();
        bus(3'd0, 1, 0, 0, 32'h0);
        bus(3'd5, 1, 0, 0, 32'h0);
        chk("fall_irq", {31'h0, irq}, 32'h0);

        bus(3'd6, 0, 1, 32'h2, 32'h0);
        bus(3'd4, 0, 1, 32'h0, 32'h0);
        in_export[1] = 1'b1;
        repeat (22) cyc();
        bus(3'd5, 1, 0, 0, 32'h2);
        chk("both_irq_masked", {31'h0, irq}, 32'h0);

        // Clear of bit 1 lands on the same edge that captures its falling edge
        in_export[1] = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k == 19) begin
                avs_write     = 1'b1;
                avs_address   = 3'd5;
                avs_writedata = 32'h2;
            end
            cyc();
            chk($sformatf("coin_irq_k%0d", k), {31'h0, irq}, 32'h0);
        end
        idle();
        bus(3'd5, 1, 0, 0, 32'h2);
        bus(3'd6, 0, 1, 32'h3, 32'h0);
        bus(3'd5, 1, 0, 0, 32'h2);
        bus(3'd5, 0, 1, 32'h2, 32'h0);
        bus(3'd5, 1, 0, 0, 32'h0);

        // Build EDGECAP=FF, return pins low, then reset mid-count on a rising change
        bus(3'd6, 0, 1, 32'h2, 32'h0);
        bus(3'd4, 0, 1, 32'hFF, 32'h0);
        in_export = 8'hFF;
        repeat (22) cyc();
        bus(3'd5, 1, 0, 0, 32'hFF);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        in_export = 8'h00;
        repeat (22) cyc();
        bus(3'd5, 1, 0, 0, 32'hFF);
        in_export = 8'hFF;
        repeat (10) cyc();
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {24'h0, out_export}, 32'hA5);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        chk("mid_rst_rdata", avs_readdata, 32'h0);
        repeat (2) cyc();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            avs_read    = 1'b1;
            avs_address = (k == 1) ? 3'd5 : (k == 2) ? 3'd4 : (k == 3) ? 3'd6 : 3'd0;
            exp_q.push_back((k >= 19) ? 32'hFF : 32'h0);
            cyc();
            chk($sformatf("post_rst_irq_k%0d", k), {31'h0, irq}, 32'h0);
        end
        idle();
        chk("post_rst_out", {24'h0, out_export}, 32'hA5);

        repeat (2) cyc();
        chk("sb_drain", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
